// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the core's dmem port.
// Decodes each access into one of these targets:
//   - null region  0000h-0001h
//   - timer COUNT  0002h-0003h
//   - timer CTRL   0004h-0005h
//   - I/O window   0006h-00ffh
//   - word RAM     0100h-3fffh
//   - unmapped     >= 4000h
// The addressed word is returned one cycle after the read strobe, and the
// block drives the timer interrupt request.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   dmem_ren/wen/byt    read strobe, write strobe, byte-access flag
//   dmem_addr           byte address
//   dmem_wdata          lane-positioned write data (odd byte [15:8])
//   dmem_rdata          word captured at the last read strobe
//   irq                 registered IF & IE
//   io_ren/io_wen       strobes qualified by the I/O window
//   io_addr/io_wdata/io_byt   pass-through to peripherals
//   io_rdata            combinational peripheral read word
module dmem_ctrl #(
  parameter int unsigned CLOCK_HZ  = 27_000_000,
  parameter int unsigned RAM_WORDS = 8064
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic        dmem_byt,
  input  logic [15:0] dmem_addr,
  input  logic [15:0] dmem_wdata,
  output logic [15:0] dmem_rdata,
  output logic        irq,
  output logic        io_ren,
  output logic        io_wen,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  output logic        io_byt,
  input  logic [15:0] io_rdata
);

  localparam int unsigned TICK_DIV = CLOCK_HZ / 1000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam int unsigned AW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Address decode and lane enables
  logic          sel_count;
  logic          sel_ctrl;
  logic          sel_io;
  logic          sel_ram;
  logic [15:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          lane_lo;
  logic          lane_hi;

  always_comb begin
    sel_count = (dmem_addr[15:1] == 15'd1);
    sel_ctrl  = (dmem_addr[15:1] == 15'd2);
    sel_io    = (dmem_addr >= 16'h0006) && (dmem_addr <= 16'h00ff);
    ram_off   = (dmem_addr - 16'h0100) >> 1;
    sel_ram   = (dmem_addr >= 16'h0100) && (dmem_addr <= 16'h3fff) &&
                (32'(ram_off) < RAM_WORDS);
    ram_idx   = ram_off[AW-1:0];
    lane_lo   = !dmem_byt || !dmem_addr[0];
    lane_hi   = !dmem_byt ||  dmem_addr[0];
  end

  // Peripheral pass-through
  always_comb begin
    io_ren   = dmem_ren && sel_io;
    io_wen   = dmem_wen && sel_io;
    io_addr  = dmem_addr[7:0];
    io_wdata = dmem_wdata;
    io_byt   = dmem_byt;
  end

  // Word RAM: synchronous read port, byte-lane write, contents not reset.
  // The read is sampled before the write, giving read-before-write.
  logic [15:0] ram [RAM_WORDS];
  logic [15:0] ram_q;

  always_ff @(posedge clk) begin
    if (dmem_ren && sel_ram) ram_q <= ram[ram_idx];
    if (dmem_wen && sel_ram) begin
      if (lane_lo) ram[ram_idx][7:0]  <= dmem_wdata[7:0];
      if (lane_hi) ram[ram_idx][15:8] <= dmem_wdata[15:8];
    end
  end

  // Countdown timer
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic          int_flag;
  logic          int_en;
  logic          tick;
  logic          count_wr;
  logic          ctrl_wr;
  logic          expire;

  always_comb begin
    tick     = (presc == PRE_MAX);
    count_wr = dmem_wen && sel_count;
    ctrl_wr  = dmem_wen && sel_ctrl && lane_lo;
    // A COUNT write suppresses the tick, so it can never expire that cycle.
    expire   = tick && !count_wr && (count == 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      count    <= '0;
      int_flag <= 1'b0;
      int_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= int_flag & int_en;
      if (count_wr) begin
        presc <= '0;
        if (lane_lo) count[7:0]  <= dmem_wdata[7:0];
        if (lane_hi) count[15:8] <= dmem_wdata[15:8];
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && (count != '0)) count <= count - 1'b1;
      end
      if (ctrl_wr) begin
        int_flag <= dmem_wdata[0];
        int_en   <= dmem_wdata[1];
      end
      // Expiry is placed after the CTRL write so a racing clear cannot drop it.
      if (expire) int_flag <= 1'b1;
    end
  end

  // Read path: register word for non-RAM targets, plus a flag steering the
  // output to the RAM read port when the last read addressed RAM.
  logic [15:0] reg_word;
  logic [15:0] reg_q;
  logic        rd_ram;

  always_comb begin
    reg_word = '0;
    if (sel_count)     reg_word = count;
    else if (sel_ctrl) reg_word = {14'b0, int_en, int_flag};
    else if (sel_io)   reg_word = io_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= '0;
      rd_ram <= 1'b0;
    end else if (dmem_ren) begin
      reg_q  <= reg_word;
      rd_ram <= sel_ram;
    end
  end

  always_comb begin
    dmem_rdata = rd_ram ? ram_q : reg_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a
// byte-level behavioural model (CLOCK_HZ=10000, so one tick every 10 cycles).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, ren, wen, byt;
  logic [15:0] addr, wdata, io_rdata;
  logic [15:0] dmem_rdata;
  logic        irq, io_ren, io_wen, io_byt;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;

  dmem_ctrl #(.CLOCK_HZ(10000), .RAM_WORDS(8064)) dut (
    .clk(clk), .rst(rst), .dmem_ren(ren), .dmem_wen(wen), .dmem_byt(byt),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(dmem_rdata), .irq(irq),
    .io_ren(io_ren), .io_wen(io_wen), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_byt(io_byt), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [7:0]  mem_b [int];
  logic [15:0] m_count = '0;
  logic        m_if = 1'b0, m_ie = 1'b0, m_irq = 1'b0;
  int          m_since = 0;
  logic [15:0] m_rdata = '0;
  logic        m_known = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {15'b0, obs}, {15'b0, exp});
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic b,
                                        input logic a0, input logic [15:0] wd);
    if (!b) return wd;
    return a0 ? {wd[15:8], old[7:0]} : {old[15:8], wd[7:0]};
  endfunction

  task automatic m_read(input logic [15:0] a, input logic [15:0] iod,
                        output logic [15:0] v, output logic k);
    int lo;
    v = '0;
    k = 1'b1;
    if (a < 16'd2)               v = '0;
    else if (a < 16'd4)          v = m_count;
    else if (a < 16'd6)          v = {14'b0, m_ie, m_if};
    else if (a <= 16'h00ff)      v = iod;
    else if (a <= 16'h3fff) begin
      lo = int'(a) & ~1;
      if (mem_b.exists(lo) && mem_b.exists(lo + 1)) v = {mem_b[lo + 1], mem_b[lo]};
      else k = 1'b0;
    end
  endtask

  task automatic m_edge(input logic r, input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] iod, input logic rs);
    logic [15:0] v;
    logic        k;
    logic        irq_next;
    logic        tick;
    logic        set_if;
    int          lo;
    if (rs) begin
      m_count = '0; m_if = 1'b0; m_ie = 1'b0; m_irq = 1'b0;
      m_since = 0; m_rdata = '0; m_known = 1'b1;
      return;
    end
    irq_next = m_if & m_ie;
    tick     = (m_since % 10) == 9;
    set_if   = 1'b0;
    if (r) begin
      m_read(a, iod, v, k);
      m_rdata = v;
      m_known = k;
    end
    if (w && (a == 16'd2 || a == 16'd3)) begin
      m_count = merge(m_count, b, a[0], wd);
      m_since = 0;
    end else begin
      m_since++;
      if (tick && m_count != 16'd0) begin
        if (m_count == 16'd1) set_if = 1'b1;
        m_count = m_count - 16'd1;
      end
    end
    if (w && (a == 16'd4 || (a == 16'd5 && !b))) begin
      m_if = wd[0];
      m_ie = wd[1];
    end
    if (set_if) m_if = 1'b1;
    if (w && a >= 16'h0100 && a <= 16'h3fff) begin
      lo = int'(a) & ~1;
      if (!b) begin
        mem_b[lo]     = wd[7:0];
        mem_b[lo + 1] = wd[15:8];
      end else begin
        mem_b[int'(a)] = a[0] ? wd[15:8] : wd[7:0];
      end
    end
    m_irq = irq_next;
  endtask

  // One bus cycle: drive at the falling edge, check the pass-through paths,
  // advance the model, then check registered outputs just after the edge.
  task automatic cyc(input logic r, input logic w, input logic b,
                     input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] iod, input logic rs);
    logic in_io;
    @(negedge clk);
    rst = rs; ren = r; wen = w; byt = b; addr = a; wdata = wd; io_rdata = iod;
    #1;
    in_io = (a >= 16'h0006) && (a <= 16'h00ff);
    chk1("io_ren", io_ren, r && in_io);
    chk1("io_wen", io_wen, w && in_io);
    chk("io_addr", {8'b0, io_addr}, {8'b0, a[7:0]});
    chk("io_wdata", io_wdata, wd);
    chk1("io_byt", io_byt, b);
    m_edge(r, w, b, a, wd, iod, rs);
    @(posedge clk);
    #1;
    chk1("irq", irq, m_irq);
    if (m_known) chk("rdata", dmem_rdata, m_rdata);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic wr(input logic b, input logic [15:0] a, input logic [15:0] wd);
    cyc(1'b0, 1'b1, b, a, wd, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] iod);
    cyc(1'b1, 1'b0, 1'b0, a, 16'h0000, iod, 1'b0);
  endtask

  initial begin
    logic        r, w, b, rs;
    logic [15:0] a, wd, iod;
    int unsigned cls;

    rst = 1'b1; ren = 1'b0; wen = 1'b0; byt = 1'b0;
    addr = '0; wdata = '0; io_rdata = '0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("reset_rdata", dmem_rdata, 16'h0000);
    chk1("reset_irq", irq, 1'b0);

    // RAM word round-trip
    wr(1'b0, 16'h0100, 16'h1234);
    rd(16'h0100, 16'h0000);
    chk("ram_word", dmem_rdata, 16'h1234);

    // RAM byte lanes
    wr(1'b1, 16'h0200, 16'h00ab);
    wr(1'b1, 16'h0201, 16'hcd00);
    rd(16'h0200, 16'h0000);
    chk("ram_bytes_even", dmem_rdata, 16'hcdab);
    rd(16'h0201, 16'h0000);
    chk("ram_bytes_odd", dmem_rdata, 16'hcdab);

    // Timer expiry: COUNT=3 reaches 0 at the 30th cycle after the write
    wr(1'b0, 16'h0004, 16'h0002);
    wr(1'b0, 16'h0002, 16'h0003);
    for (int i = 0; i < 29; i++) begin
      idle();
      chk1("irq_quiet", irq, 1'b0);
    end
    rd(16'h0002, 16'h0000);
    chk("count_before_expiry", dmem_rdata, 16'h0001);
    chk1("irq_at_expiry", irq, 1'b0);
    rd(16'h0004, 16'h0000);
    chk("ctrl_after_expiry", dmem_rdata, 16'h0003);
    chk1("irq_raised", irq, 1'b1);
    rd(16'h0002, 16'h0000);
    chk("count_zero", dmem_rdata, 16'h0000);

    // Clear race: CTRL write of 0002h on the cycle COUNT goes 1->0
    wr(1'b0, 16'h0004, 16'h0002);
    wr(1'b0, 16'h0002, 16'h0001);
    for (int i = 0; i < 9; i++) idle();
    wr(1'b0, 16'h0004, 16'h0002);
    rd(16'h0004, 16'h0000);
    chk("race_ctrl", dmem_rdata, 16'h0003);
    chk1("race_irq", irq, 1'b1);

    // I/O window and unmapped space
    cyc(1'b1, 1'b0, 1'b0, 16'h0006, 16'h0000, 16'h5a5a, 1'b0);
    chk("io_read", dmem_rdata, 16'h5a5a);
    wr(1'b0, 16'h0080, 16'hffff);
    rd(16'h0002, 16'h0000);
    chk("io_write_count", dmem_rdata, 16'h0000);
    rd(16'h0004, 16'h0000);
    chk("io_write_ctrl", dmem_rdata, 16'h0003);
    rd(16'h4000, 16'h0000);
    chk("unmapped", dmem_rdata, 16'h0000);

    // Reset mid-operation, with a RAM read pending
    wr(1'b0, 16'h0004, 16'h0003);
    wr(1'b0, 16'h0002, 16'h0005);
    chk1("irq_pre_reset", irq, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
    chk1("reset_mid_irq", irq, 1'b0);
    chk("reset_mid_rdata", dmem_rdata, 16'h0000);
    rd(16'h0002, 16'h0000);
    chk("reset_count", dmem_rdata, 16'h0000);
    rd(16'h0004, 16'h0000);
    chk("reset_ctrl", dmem_rdata, 16'h0000);
    rd(16'h0100, 16'h0000);
    chk("reset_ram_kept", dmem_rdata, 16'h1234);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cls = $urandom_range(0, 9);
      r   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      wd  = 16'($urandom);
      iod = 16'($urandom);
      case (cls)
        0, 1:    a = 16'($urandom_range(0, 7));
        2:       a = 16'($urandom_range(6, 255));
        3, 4:    a = 16'($urandom_range(16'h0100, 16'h010f));
        5:       a = 16'($urandom_range(16'h3ff0, 16'h3fff));
        6:       a = 16'($urandom_range(16'h4000, 16'hffff));
        7:       a = 16'($urandom);
        default: begin a = '0; r = 1'b0; w = 1'b0; end
      endcase
      if (a == 16'd2 || a == 16'd3) wd = 16'($urandom_range(0, 3));
      rs = ($urandom_range(0, 99) == 0);
      if (rs) w = 1'b0;
      cyc(r, w, b, a, wd, iod, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the CPU core's dmem port. It decodes every CPU data access into one of three targets: on-chip word RAM (0100h–3fffh), the built-in countdown timer registers (002h–005h), or an external I/O window (006h–00ffh) forwarded to peripherals. It returns the addressed 16-bit word to the core one cycle later and raises the timer interrupt request.

## Interface
- CLOCK_HZ, 27_000_000, core clock frequency; timer tick divider TICK_DIV = CLOCK_HZ/1000 (1 ms tick).
- RAM_WORDS, 8064, RAM depth in 16-bit words, covering 0100h–3fffh.

- clk  in  1  core clock.
- rst  in  1  reset; synchronous and active-high.
- dmem_ren  in  1  read strobe from the core.
- dmem_wen  in  1  write strobe from the core.
- dmem_byt  in  1  byte access when 1.
- dmem_addr  in  16  byte address from the core.
- dmem_wdata  in  16  write data, already lane-positioned by the core: odd byte on [15:8], even byte on [7:0].
- dmem_rdata  out  16  full 16-bit word at the previous cycle's address; the core extracts the byte.
- irq  out  1  timer interrupt request, equal to IF & IE.
- io_ren, io_wen  out  1 each  ren/wen qualified by 006h ≤ addr ≤ 00ffh.
- io_addr  out  8  dmem_addr[7:0].
- io_wdata  out  16  dmem_wdata passed through unchanged.
- io_byt  out  1  dmem_byt passed through unchanged.
- io_rdata  in  16  peripheral read word; sampled in the same cycle as io_ren.

## Operation
- Address decode on dmem_addr:
  - 0000h–0001h: null region; reads return 0 and writes are ignored.
  - 0002h–0003h: COUNT.
  - 0004h–0005h: CTRL.
  - 0006h–00ffh: I/O window.
  - 0100h–3fffh: RAM.
  - ≥4000h: unmapped; reads return 0 and writes are ignored.
- Word access (byt=0):
  - Ignores addr[0].
  - Writes both lanes from wdata[15:0].
- Byte access (byt=1):
  - addr[0]=0 writes the low lane from wdata[7:0].
  - addr[0]=1 writes the high lane from wdata[15:8].
  - The other lane is unchanged.
  - Applies to RAM, COUNT and CTRL alike.
- RAM:
  - Word index is (addr − 0100h) >> 1.
  - Contents are not reset.
- COUNT (16 bit):
  - Free-running prescaler counts 0..TICK_DIV−1; tick is the cycle in which it wraps to 0.
  - On a tick, COUNT decrements if it is nonzero and holds at 0 otherwise.
  - When the decrement takes COUNT from 1 to 0, IF is set.
  - Any write to COUNT (either lane) loads the new value, resets the prescaler to 0 and suppresses that cycle's tick.
  - Writing 0 does not set IF.
- CTRL:
  - Reads as {14'b0, IE, IF}.
  - A write to the low lane loads IF←wdata[0] and IE←wdata[1]; a high-lane write is ignored.
  - Writing IF=1 is allowed (software-triggered interrupt).
- irq = IF & IE, registered output.
- Read path: a read of COUNT or CTRL returns the value before any same-cycle tick or write.

## Timing
- Read latency is 1 cycle:
  - The word addressed while dmem_ren=1 in cycle N appears on dmem_rdata from the rising edge ending cycle N.
  - It holds until the next cycle with dmem_ren=1.
- I/O reads: io_rdata is captured at the same edge; peripherals must present it combinationally from io_addr.
- Writes complete at the rising edge of the cycle in which wen=1. A read of the same address in cycle N+1 returns the new data.
- ren and wen in the same cycle:
  - The write is performed.
  - dmem_rdata returns the pre-write word (read-before-write).
- irq timing:
  - irq rises 1 cycle after the edge that sets IF.
  - irq falls 1 cycle after IF or IE clears.
- Simultaneous events:
  - COUNT reaching 0 in the same cycle as a CTRL write with wdata[0]=0: set wins, so IF=1 and no interrupt is lost.
  - COUNT write coinciding with a tick: the write wins and no decrement occurs.
- Reset (synchronous, any time, including mid-access):
  - dmem_rdata=0, irq=0, COUNT=0, IF=0, IE=0, prescaler=0.
  - A pending read result is discarded.
  - io_ren and io_wen are combinational and follow their inputs.

## Test plan
Bench uses CLOCK_HZ=10000, so TICK_DIV=10.
- RAM word round-trip: word write 1234h @0100h, then read @0100h → dmem_rdata=1234h one cycle after the read strobe.
- RAM byte lanes: byte write 00ABh @0200h, then byte write CD00h @0201h, then word read @0200h → CDABh; word read @0201h → CDABh.
- Timer expiry:
  - Write CTRL=0002h, then COUNT=0003h.
  - irq=0 for the first 29 cycles after the write.
  - COUNT reaches 0 at cycle 30 (first tick exactly 10 cycles after the write) and IF=1.
  - irq=1 one cycle later.
  - Reading CTRL returns 0003h.
- Interrupt clear race: arrange a CTRL write of 0002h in the exact cycle COUNT goes 1→0 → IF=1 and irq=1 afterward.
- I/O window:
  - Read @0006h with io_rdata=5A5Ah → io_ren=1 that cycle and dmem_rdata=5A5Ah next cycle.
  - Write @0080h → io_wen=1 and no RAM, COUNT or CTRL change.
  - Read @4000h → 0000h.
- Reset mid-operation: assert rst while COUNT=0005h, IE=1, IF=1 → next cycle irq=0, COUNT=0, CTRL reads 0000h, RAM contents preserved.
